// File: rtl/npg_pkg.sv
// Shared types and defaults for the NPG stimulation scheduler.
package npg_pkg;

   localparam int NSLOT_DEF  = 4;
   localparam int GAP_DEF    = 20;
   localparam int ELEC_W_DEF = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STIM,
      ST_DRAIN,
      ST_GAP
   } state_t;

   typedef struct packed {
      logic [5:0] amp;
      logic [4:0] e1;
      logic [4:0] e2;
      logic [7:0] pulses;
   } slot_t;

   // A slot with no pulses or a shorted electrode pair is never stimulated.
   function automatic logic slot_valid(slot_t s);
      return (s.pulses != 8'd0) && (s.e1 != s.e2);
   endfunction

endpackage

// File: rtl/npg_scheduler_if.sv
// Control, configuration and NPG-facing signals of the stimulation scheduler.
interface npg_scheduler_if #(
   parameter int NSLOT  = npg_pkg::NSLOT_DEF,
   parameter int ELEC_W = npg_pkg::ELEC_W_DEF
);
   localparam int AW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

   logic              start;
   logic              stop;
   logic              loop;
   logic              cfg_we;
   logic [AW-1:0]     cfg_addr;
   logic [5:0]        cfg_amp;
   logic [4:0]        cfg_e1;
   logic [4:0]        cfg_e2;
   logic [7:0]        cfg_pulses;
   logic              pulse_active;

   logic              npg_enable;
   logic [5:0]        amplitude;
   logic [ELEC_W-1:0] electrode1;
   logic [ELEC_W-1:0] electrode2;
   logic              busy;
   logic [AW-1:0]     cur_slot;
   logic              done;
   logic              cfg_err;

   modport master (
      output start, stop, loop, cfg_we, cfg_addr, cfg_amp, cfg_e1, cfg_e2,
             cfg_pulses, pulse_active,
      input  npg_enable, amplitude, electrode1, electrode2, busy, cur_slot,
             done, cfg_err
   );

   modport slave (
      input  start, stop, loop, cfg_we, cfg_addr, cfg_amp, cfg_e1, cfg_e2,
             cfg_pulses, pulse_active,
      output npg_enable, amplitude, electrode1, electrode2, busy, cur_slot,
             done, cfg_err
   );

endinterface

// File: rtl/elec_decode.sv
// Electrode index to one-hot select; indices beyond ELEC_W decode to all-zero.
module elec_decode #(
   parameter int ELEC_W = 32
) (
   input  logic [4:0]        idx_i,
   output logic [ELEC_W-1:0] onehot_o
);

   generate
      for (genvar gi = 0; gi < ELEC_W; gi++) begin : g_bit
         assign onehot_o[gi] = (int'(idx_i) == gi);
      end
   endgenerate

endmodule

// File: rtl/npg_scheduler.sv
// Walks a small table of stimulation slots, enabling the NPG for a set number
// of biphasic pulses per slot with a fixed idle gap between slots.
module npg_scheduler
   import npg_pkg::*;
#(
   parameter int NSLOT  = NSLOT_DEF,
   parameter int GAP    = GAP_DEF,
   parameter int ELEC_W = ELEC_W_DEF
) (
   input  logic            clk,
   input  logic            resetn,
   npg_scheduler_if.slave  bus
);

   localparam int AW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam int GW = $clog2(GAP + 1);

   slot_t             table_q [NSLOT];
   logic [NSLOT-1:0]  valid;
   state_t            state_q;
   logic [AW-1:0]     slot_q;
   logic [AW-1:0]     cur_slot_q;
   logic [7:0]        cnt_q;
   logic [7:0]        cnt_d;
   logic [GW-1:0]     gap_q;
   logic              pa_q;
   logic              npg_enable_q;
   logic              done_q;
   logic              cfg_err_q;
   logic [5:0]        amp_q;
   logic [ELEC_W-1:0] elec1_q;
   logic [ELEC_W-1:0] elec2_q;
   logic [ELEC_W-1:0] elec1_dec;
   logic [ELEC_W-1:0] elec2_dec;
   logic [7:0]        cur_pulses;
   logic              fall;
   logic              first_found;
   logic [AW-1:0]     first_idx;
   logic              higher_found;
   logic [AW-1:0]     higher_idx;

   generate
      for (genvar gi = 0; gi < NSLOT; gi++) begin : g_valid
         assign valid[gi] = slot_valid(table_q[gi]);
      end
   endgenerate

   // Lowest valid slot overall, and lowest valid slot above the one in use.
   always_comb begin
      first_found  = 1'b0;
      first_idx    = '0;
      higher_found = 1'b0;
      higher_idx   = '0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (valid[i]) begin
            first_found = 1'b1;
            first_idx   = AW'(i);
         end
         if (valid[i] && (i > int'(cur_slot_q))) begin
            higher_found = 1'b1;
            higher_idx   = AW'(i);
         end
      end
   end

   elec_decode #(.ELEC_W(ELEC_W)) u_dec1 (
      .idx_i    (table_q[slot_q].e1),
      .onehot_o (elec1_dec)
   );

   elec_decode #(.ELEC_W(ELEC_W)) u_dec2 (
      .idx_i    (table_q[slot_q].e2),
      .onehot_o (elec2_dec)
   );

   assign cur_pulses = table_q[cur_slot_q].pulses;
   assign fall       = pa_q & ~bus.pulse_active;
   assign cnt_d      = (cnt_q < cur_pulses) ? cnt_q + 8'd1 : cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NSLOT; i++) begin
            table_q[i] <= '0;
         end
      end else if (bus.cfg_we && (state_q == ST_IDLE)) begin
         table_q[bus.cfg_addr] <= '{amp:    bus.cfg_amp,
                                    e1:     bus.cfg_e1,
                                    e2:     bus.cfg_e2,
                                    pulses: bus.cfg_pulses};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         slot_q       <= '0;
         cur_slot_q   <= '0;
         cnt_q        <= '0;
         gap_q        <= '0;
         pa_q         <= 1'b0;
         npg_enable_q <= 1'b0;
         done_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
         amp_q        <= '0;
         elec1_q      <= '0;
         elec2_q      <= '0;
      end else begin
         pa_q      <= bus.pulse_active;
         done_q    <= 1'b0;
         cfg_err_q <= bus.cfg_we && (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (bus.start && !bus.stop) begin
                  if (first_found) begin
                     slot_q  <= first_idx;
                     state_q <= ST_LOAD;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (bus.stop) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end else begin
                  amp_q        <= table_q[slot_q].amp;
                  elec1_q      <= elec1_dec;
                  elec2_q      <= elec2_dec;
                  cur_slot_q   <= slot_q;
                  cnt_q        <= '0;
                  npg_enable_q <= 1'b1;
                  state_q      <= ST_STIM;
               end
            end
            ST_STIM: begin
               if (bus.stop) begin
                  npg_enable_q <= 1'b0;
                  // Let a pulse in flight complete its biphasic cycle.
                  if (bus.pulse_active) begin
                     state_q <= ST_DRAIN;
                  end else begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end
               end else if (fall) begin
                  cnt_q <= cnt_d;
                  if (cnt_d == cur_pulses) begin
                     npg_enable_q <= 1'b0;
                     gap_q        <= '0;
                     state_q      <= ST_GAP;
                  end
               end
            end
            ST_DRAIN: begin
               if (!bus.pulse_active) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end
            end
            ST_GAP: begin
               if (bus.stop) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end else if (gap_q == GW'(GAP - 1)) begin
                  if (higher_found || bus.loop) begin
                     slot_q  <= higher_found ? higher_idx : first_idx;
                     state_q <= ST_LOAD;
                  end else begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.npg_enable = npg_enable_q;
   assign bus.amplitude  = amp_q;
   assign bus.electrode1 = elec1_q;
   assign bus.electrode2 = elec2_q;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.cur_slot   = cur_slot_q;
   assign bus.done       = done_q;
   assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_npg_scheduler.sv
// Randomised and directed checks of npg_scheduler against a slot-visit level model.
module tb_npg_scheduler;
   import npg_pkg::*;

   localparam int NSLOT  = 4;
   localparam int GAP    = 20;
   localparam int ELEC_W = 32;
   localparam int AW     = 2;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   npg_scheduler_if #(.NSLOT(NSLOT), .ELEC_W(ELEC_W)) bus ();

   npg_scheduler #(.NSLOT(NSLOT), .GAP(GAP), .ELEC_W(ELEC_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int err_cnt = 0;
   int chk_cnt = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Model of the slot table as written through the configuration port.
   int m_amp [NSLOT];
   int m_e1  [NSLOT];
   int m_e2  [NSLOT];
   int m_pul [NSLOT];

   function automatic bit m_valid(input int i);
      return (m_pul[i] != 0) && (m_e1[i] != m_e2[i]);
   endfunction

   int exp_q [$];
   int obs_q [$];
   int visits = 0;
   int falls = 0;
   int low_run = 0;
   int last_slot = -1;
   int hi_cnt = 0;
   int lo_cnt = 0;
   bit en_prev = 1'b0;
   bit done_seen = 1'b0;
   bit busy_seen = 1'b0;
   bit stop_issued = 1'b0;
   bit hold_pa = 1'b0;

   // Monitor plus a simple NPG: emits pulses while enabled, never truncates one.
   always @(negedge clk) begin : mon
      int s;
      if (!resetn) begin
         bus.pulse_active = 1'b0;
         hi_cnt  = 0;
         lo_cnt  = 0;
         en_prev = 1'b0;
         falls   = 0;
         low_run = 0;
      end else begin
         if (bus.busy) busy_seen = 1'b1;
         if (bus.npg_enable && !en_prev) begin
            s = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            check_eq("visit_slot", bus.cur_slot, s);
            if (s >= 0) begin
               check_eq("visit_amp", bus.amplitude, m_amp[s]);
               check_eq("visit_e1", bus.electrode1, 64'd1 << m_e1[s]);
               check_eq("visit_e2", bus.electrode2, 64'd1 << m_e2[s]);
            end
            if (visits > 0 && !stop_issued) check_eq("gap_len", low_run, GAP + 1);
            $display("visit %0d slot=%0d amp=%0d e1=0x%0h e2=0x%0h",
                     visits, bus.cur_slot, bus.amplitude, bus.electrode1, bus.electrode2);
            obs_q.push_back(int'(bus.cur_slot));
            visits++;
            falls = 0;
            last_slot = s;
         end
         if (!bus.npg_enable && en_prev) begin
            if (!stop_issued && last_slot >= 0)
               check_eq("pulses_per_visit", falls, m_pul[last_slot]);
            low_run = 0;
         end
         if (!bus.npg_enable) low_run++;
         if (bus.done) begin
            if (!stop_issued && visits > 0) begin
               check_eq("done_after_gap", low_run, GAP + 1);
               check_eq("visits_left", exp_q.size(), 0);
            end
            done_seen = 1'b1;
            $display("done after %0d visits", visits);
         end
         if (bus.pulse_active) begin
            if (!hold_pa) begin
               if (hi_cnt > 1) hi_cnt--;
               else begin
                  bus.pulse_active = 1'b0;
                  lo_cnt = $urandom_range(1, 3);
                  if (bus.npg_enable) falls++;
               end
            end
         end else begin
            if (lo_cnt > 0) lo_cnt--;
            if (lo_cnt == 0 && bus.npg_enable) begin
               bus.pulse_active = 1'b1;
               hi_cnt = $urandom_range(1, 4);
            end
         end
         en_prev = bus.npg_enable;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic write_slot(input int a, input int amp, input int e1, input int e2,
                             input int pul, input bit upd);
      bus.cfg_we     = 1'b1;
      bus.cfg_addr   = AW'(a);
      bus.cfg_amp    = 6'(amp);
      bus.cfg_e1     = 5'(e1);
      bus.cfg_e2     = 5'(e2);
      bus.cfg_pulses = 8'(pul);
      tick();
      bus.cfg_we = 1'b0;
      if (upd) begin
         m_amp[a] = amp;
         m_e1[a]  = e1;
         m_e2[a]  = e2;
         m_pul[a] = pul;
      end
   endtask

   task automatic begin_run(input bit lp);
      exp_q.delete();
      obs_q.delete();
      for (int r = 0; r < (lp ? 10 : 1); r++)
         for (int i = 0; i < NSLOT; i++)
            if (m_valid(i)) exp_q.push_back(i);
      visits      = 0;
      done_seen   = 1'b0;
      busy_seen   = 1'b0;
      stop_issued = 1'b0;
      bus.loop    = lp;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic stop_now();
      stop_issued = 1'b1;
      bus.stop    = 1'b1;
      tick();
      bus.stop = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!done_seen && n < budget) begin
         tick();
         n++;
      end
      check_eq(tag, done_seen, 1);
   endtask

   task automatic wait_visits(input string tag, input int cnt, input int budget);
      int n = 0;
      while (visits < cnt && n < budget) begin
         tick();
         n++;
      end
      check_eq(tag, visits >= cnt, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int nvalid;
      int amp, e1, e2, pul;
      bit lp;
      bus.start = 1'b0;  bus.stop = 1'b0;  bus.loop = 1'b0;  bus.cfg_we = 1'b0;
      bus.cfg_addr = '0; bus.cfg_amp = '0; bus.cfg_e1 = '0;  bus.cfg_e2 = '0;
      bus.cfg_pulses = '0;
      for (int i = 0; i < NSLOT; i++) begin
         m_amp[i] = 0; m_e1[i] = 0; m_e2[i] = 0; m_pul[i] = 0;
      end
      repeat (3) @(posedge clk);
      #2;
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_enable", bus.npg_enable, 0);
      check_eq("rst_done", bus.done, 0);
      check_eq("rst_cfg_err", bus.cfg_err, 0);
      check_eq("rst_cur_slot", bus.cur_slot, 0);
      check_eq("rst_amp", bus.amplitude, 0);
      check_eq("rst_e1", bus.electrode1, 0);
      check_eq("rst_e2", bus.electrode2, 0);
      resetn = 1'b1;
      tick();

      // Single slot, single pass.
      write_slot(0, 50, 15, 14, 3, 1'b1);
      check_eq("idle_write_no_err", bus.cfg_err, 0);
      begin_run(1'b0);
      wait_done("t1_done", 300);
      check_eq("t1_visits", visits, 1);
      check_eq("t1_e1_hold", bus.electrode1, 64'h8000);
      check_eq("t1_e2_hold", bus.electrode2, 64'h4000);
      check_eq("t1_amp_hold", bus.amplitude, 50);
      check_eq("t1_busy_end", bus.busy, 0);

      // Looping over slots 0 and 2 with an invalid slot 1 between them.
      write_slot(1, 7, 3, 3, 2, 1'b1);
      write_slot(2, 20, 0, 31, 2, 1'b1);
      begin_run(1'b1);
      wait_visits("t2_visits", 4, 1000);
      for (int k = 0; k < 4; k++)
         check_eq($sformatf("t2_seq%0d", k), obs_q[k], (k % 2 == 0) ? 0 : 2);
      stop_now();
      wait_done("t2_done", 100);

      // Stop while a pulse is in flight.
      begin_run(1'b1);
      n = 0;
      while (!(bus.npg_enable && bus.pulse_active) && n < 300) begin
         tick();
         n++;
      end
      check_eq("t3_in_pulse", bus.npg_enable && bus.pulse_active, 1);
      hold_pa = 1'b1;
      stop_now();
      check_eq("t3_enable_off", bus.npg_enable, 0);
      check_eq("t3_busy_drain", bus.busy, 1);
      repeat (3) tick();
      check_eq("t3_no_early_done", done_seen, 0);
      check_eq("t3_still_busy", bus.busy, 1);
      hold_pa = 1'b0;
      wait_done("t3_done", 50);
      check_eq("t3_idle", bus.busy, 0);
      check_eq("t3_enable_idle", bus.npg_enable, 0);

      // Writes while busy are rejected and leave the table alone.
      begin_run(1'b0);
      repeat (3) tick();
      write_slot(3, 10, 1, 2, 1, 1'b0);
      check_eq("t4_cfg_err", bus.cfg_err, 1);
      tick();
      check_eq("t4_cfg_err_pulse", bus.cfg_err, 0);
      stop_now();
      wait_done("t4_stop_done", 100);
      begin_run(1'b0);
      wait_done("t4_rerun_done", 500);
      check_eq("t4_rerun_visits", visits, 2);

      // Start and stop together in IDLE.
      visits = 0;
      busy_seen = 1'b0;
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      repeat (5) tick();
      check_eq("t5_no_busy", busy_seen, 0);
      check_eq("t5_no_visit", visits, 0);

      // Random tables and modes.
      for (int it = 0; it < 6; it++) begin
         nvalid = 0;
         for (int i = 0; i < NSLOT; i++) begin
            amp = $urandom_range(0, 63);
            e1  = $urandom_range(0, 31);
            e2  = ($urandom_range(0, 3) == 0) ? e1 : $urandom_range(0, 31);
            pul = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3);
            write_slot(i, amp, e1, e2, pul, 1'b1);
            if (m_valid(i)) nvalid++;
         end
         lp = 1'($urandom_range(0, 1));
         begin_run(lp);
         if (lp && nvalid > 0) begin
            wait_visits("rnd_loop_visits", nvalid + 1, 1500);
            repeat ($urandom_range(0, 30)) tick();
            stop_now();
            wait_done("rnd_stop_done", 100);
         end else begin
            wait_done("rnd_done", 1500);
            check_eq("rnd_visits", visits, nvalid);
         end
         tick();
         check_eq("rnd_idle", bus.busy, 0);
         $display("run %0d loop=%0d valid=%0d visits=%0d", it, lp, nvalid, visits);
      end

      // Asynchronous reset in the middle of stimulation.
      write_slot(0, 33, 4, 9, 3, 1'b1);
      begin_run(1'b0);
      n = 0;
      while (!bus.npg_enable && n < 100) begin
         tick();
         n++;
      end
      check_eq("t7_in_stim", bus.npg_enable, 1);
      tick();
      #1;
      resetn = 1'b0;
      #1;
      check_eq("t7_enable", bus.npg_enable, 0);
      check_eq("t7_busy", bus.busy, 0);
      check_eq("t7_amp", bus.amplitude, 0);
      check_eq("t7_e1", bus.electrode1, 0);
      check_eq("t7_e2", bus.electrode2, 0);
      check_eq("t7_cur_slot", bus.cur_slot, 0);
      check_eq("t7_done", bus.done, 0);
      for (int i = 0; i < NSLOT; i++) begin
         m_amp[i] = 0; m_e1[i] = 0; m_e2[i] = 0; m_pul[i] = 0;
      end
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      begin_run(1'b0);
      wait_done("t7_empty_done", 20);
      repeat (3) tick();
      check_eq("t7_empty_busy", busy_seen, 0);
      check_eq("t7_empty_visits", visits, 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/npg_scheduler.md
NPG_SCHEDULER -- requirements
Module: npg_scheduler

Interface
REQ-001 Parameter NSLOT, default 4: number of stimulation slots (program table depth).
REQ-002 Parameter GAP, default 20: idle clk cycles between consecutive slots.
REQ-003 Parameter ELEC_W, default 32: electrode bus width (one-hot).
REQ-004 clk  in  1  NPG clock (20 kHz domain).
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse; begins the schedule from the lowest valid slot.
REQ-007 stop  in  1  single-cycle pulse; ends the schedule gracefully.
REQ-008 loop  in  1  1 = wrap after the last valid slot; 0 = finish after one pass.
REQ-009 cfg_we  in  1  table write strobe.
REQ-010 cfg_addr  in  $clog2(NSLOT)  slot index.
REQ-011 cfg_amp  in  6  slot amplitude.
REQ-012 cfg_e1, cfg_e2  in  5 each  electrode indices.
REQ-013 cfg_pulses  in  8  pulses per slot visit.
REQ-014 pulse_active  in  1  from NPG; high during a biphasic pulse.
REQ-015 npg_enable  out  1  NPG enable.
REQ-016 amplitude  out  6  to NPG.
REQ-017 electrode1, electrode2  out  ELEC_W each  one-hot electrode selects to NPG.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 cur_slot  out  $clog2(NSLOT)  slot currently loaded.
REQ-020 done  out  1  single-cycle pulse at schedule end.
REQ-021 cfg_err  out  1  single-cycle pulse when a write is rejected.

Function
REQ-022 Table writes are accepted only in IDLE; a write while busy is dropped and cfg_err=1 on the next cycle.
REQ-023 A slot is valid iff cfg_pulses!=0 and cfg_e1!=cfg_e2; invalid slots are skipped.
REQ-024 States: IDLE, LOAD, STIM, DRAIN, GAP.
REQ-025 IDLE: start with >=1 valid slot -> LOAD (lowest valid slot); start with none valid -> done=1, remain IDLE.
REQ-026 LOAD (1 cycle): register amplitude, electrode1/2 (decoded from indices), cur_slot; clear pulse counter; -> STIM.
REQ-027 STIM: npg_enable=1; count pulse_active falling edges (registered pulse_active_d & ~pulse_active).
REQ-028 When count reaches the slot's cfg_pulses, npg_enable=0 in the same cycle as the edge is detected; -> GAP.
REQ-029 GAP: npg_enable=0 for exactly GAP cycles; then -> LOAD with the next valid slot (modulo NSLOT).
REQ-030 If no higher-index valid slot remains and loop=0, GAP ends in IDLE with done=1.
REQ-031 stop in LOAD/GAP -> IDLE next cycle, done=1.
REQ-032 stop in STIM with pulse_active=0 -> IDLE next cycle, done=1.
REQ-033 stop in STIM with pulse_active=1 -> DRAIN; npg_enable=0 immediately.
REQ-034 DRAIN: wait for pulse_active=0, then -> IDLE with done=1 (no biphasic pulse is truncated).
REQ-035 stop and start in the same cycle: stop wins; start in non-IDLE states is ignored.
REQ-036 Pulse counter is 8 bits and never wraps; it saturates at cfg_pulses.
REQ-037 amplitude/electrode outputs hold their last loaded values until the next LOAD or reset.

Reset
REQ-038 resetn=0 asynchronously forces IDLE and drives npg_enable, busy, done, cfg_err, cur_slot, amplitude, electrode1, electrode2 and all counters to 0.
REQ-039 Table contents reset to 0 (all slots invalid).
REQ-040 Reset asserted mid-STIM drops npg_enable within the reset assertion, regardless of pulse_active.

Structure
REQ-041 Shared package npg_pkg holds: state enum, slot record (amp 6, e1 5, e2 5, pulses 8), and GAP/NSLOT defaults.
REQ-042 One sub-module, elec_decode: 5-bit index -> ELEC_W one-hot, purely combinational; instantiated twice.

Verification
REQ-043 Slot0 = {amp 50, e1 15, e2 14, pulses 3}, loop=0, start -> enable high until the 3rd pulse_active fall, electrode1=0x8000, electrode2=0x4000, then GAP=20, done=1.
REQ-044 Slots 0 and 2 valid, slot 1 with e1==e2, loop=1 -> cur_slot sequence 0,2,0,2; slot 1 is never loaded.
REQ-045 stop while pulse_active=1 -> npg_enable=0 next cycle; done only after pulse_active falls; state is IDLE.
REQ-046 cfg_we while busy -> cfg_err=1 and table unchanged (checked by re-reading behaviour after stop).
REQ-047 resetn low mid-STIM -> all outputs 0 asynchronously; after release, start with an empty table -> done=1 and busy stays 0.
REQ-048 start and stop in the same cycle in IDLE -> no LOAD, busy stays 0.
